traffic_signal_monitor: RTL and testbench

Independent checker on the receiving end of the 8-bit traffic-light signal bus. Samples the 4-lane signal word driven by the light controller, decodes lane colours, tracks the phase sequence and per-phase dwell time, and raises a sticky fault with a cause code on any conflicting, malformed, out-of-order or mistimed indication. Sits beside the controller on the same clock and feeds the safety/override logic and status pins.

---
 rtl/traffic_signal_monitor_if.sv | 31 +++
 rtl/traffic_signal_monitor.sv | 153 +++++++++++++++
 tb/tb_traffic_signal_monitor.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/traffic_signal_monitor_if.sv
// Signal bus between the light controller side and the signal monitor.
//   signal_in   : 4-lane colour word, lane0=[7:6] .. lane3=[1:0]
//   clear_fault : one-cycle pulse, drops a latched fault and resyncs
//   lane_green  : per-lane green indication from the registered word
//   tracking    : monitor is following the phase sequence
//   phase_idx   : current phase 0-7 while tracking, else 0
//   last_dwell  : length in cycles of the most recently completed phase
//   fault       : sticky fault flag
//   fault_code  : cause of the first fault, 0 when no fault
interface traffic_signal_monitor_if #(
    parameter int CW = 20
) ();
    logic [7:0]    signal_in;
    logic          clear_fault;
    logic [3:0]    lane_green;
    logic          tracking;
    logic [2:0]    phase_idx;
    logic [CW-1:0] last_dwell;
    logic          fault;
    logic [2:0]    fault_code;

    modport master (
        output signal_in, clear_fault,
        input  lane_green, tracking, phase_idx, last_dwell, fault, fault_code
    );

    modport slave (
        input  signal_in, clear_fault,
        output lane_green, tracking, phase_idx, last_dwell, fault, fault_code
    );
endinterface

// File: rtl/traffic_signal_monitor.sv
// Independent checker for the 4-lane traffic-light signal word. Registers the
// word, decodes lane colours, follows the S0..S7 phase ring, measures dwell
// per phase and latches the first fault with a cause code.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : slave side of traffic_signal_monitor_if (see that file)
module traffic_signal_monitor #(
    parameter int G_CYC = 500000,
    parameter int Y_CYC = 100000,
    parameter int TOL   = 16,
    parameter int CW    = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    traffic_signal_monitor_if.slave bus
);
    typedef enum logic [1:0] {UNSYNC, TRACK, FAULT} state_e;

    localparam logic [7:0]    AY   = 8'h55;
    localparam logic [CW-1:0] G_LO = CW'(G_CYC - TOL);
    localparam logic [CW-1:0] G_HI = CW'(G_CYC + TOL + 1);
    localparam logic [CW-1:0] Y_LO = CW'(Y_CYC - TOL);
    localparam logic [CW-1:0] Y_HI = CW'(Y_CYC + TOL + 1);

    // {legal S-word, phase index}
    function automatic logic [3:0] s_lookup(input logic [7:0] w);
        case (w)
            8'h80:   return 4'b1_000;
            8'h50:   return 4'b1_001;
            8'h20:   return 4'b1_010;
            8'h14:   return 4'b1_011;
            8'h08:   return 4'b1_100;
            8'h05:   return 4'b1_101;
            8'h02:   return 4'b1_110;
            8'h41:   return 4'b1_111;
            default: return 4'b0_000;
        endcase
    endfunction

    logic [7:0]    sig_q, sig_d, prv_q, prv_d;
    logic          sig_vld_q, sig_vld_d, prv_vld_q, prv_vld_d;
    state_e        st_q, st_d;
    logic [2:0]    idx_q, idx_d, code_q, code_d;
    logic [CW-1:0] cnt_q, cnt_d, dwell_q, dwell_d;

    logic          chg, s_hit, any_inv, in_track;
    logic [2:0]    s_idx, n_green, code_new;
    logic [3:0]    lg;
    logic [CW-1:0] exp_lo, exp_hi;

    always_comb begin
        sig_d     = bus.signal_in;
        prv_d     = sig_q;
        sig_vld_d = 1'b1;
        prv_vld_d = sig_vld_q;
        st_d      = st_q;
        idx_d     = idx_q;
        code_d    = code_q;
        dwell_d   = dwell_q;
        code_new  = 3'd0;
        n_green   = 3'd0;
        any_inv   = 1'b0;
        lg        = 4'b0;

        for (int i = 0; i < 4; i++) begin
            lg[i]   = (sig_q[7-2*i -: 2] == 2'b10);
            any_inv = any_inv | (sig_q[7-2*i -: 2] == 2'b11);
            n_green = n_green + 3'(lg[i]);
        end
        {s_hit, s_idx} = s_lookup(sig_q);

        // The first sample after reset has no predecessor, so it is never a
        // change; a phase caught mid-way after reset is only observed.
        chg      = sig_vld_q && prv_vld_q && (sig_q != prv_q);
        in_track = (st_q == TRACK);
        exp_lo   = idx_q[0] ? Y_LO : G_LO;
        exp_hi   = idx_q[0] ? Y_HI : G_HI;

        // Cause codes in priority order; cnt_q at a change is the completed dwell.
        if (st_q != FAULT && sig_vld_q) begin
            if (n_green >= 3'd2)                                      code_new = 3'd1;
            else if (any_inv)                                         code_new = 3'd2;
            else if (!s_hit && sig_q != AY)                           code_new = 3'd3;
            else if (in_track && chg && !(s_hit && s_idx == idx_q + 3'd1))
                                                                      code_new = 3'd4;
            else if (in_track && chg && cnt_q < exp_lo)               code_new = 3'd5;
            else if (in_track && cnt_q >= exp_hi)                     code_new = 3'd6;
        end

        if (chg)          cnt_d = CW'(1);
        else if (&cnt_q)  cnt_d = cnt_q;
        else              cnt_d = cnt_q + CW'(1);

        if (bus.clear_fault) begin
            st_d   = UNSYNC;
            code_d = 3'd0;
            idx_d  = 3'd0;
        end else begin
            case (st_q)
                UNSYNC: begin
                    if (code_new != 3'd0) begin
                        st_d   = FAULT;
                        code_d = code_new;
                    end else if (chg && s_hit) begin
                        st_d  = TRACK;
                        idx_d = s_idx;
                    end
                end
                TRACK: begin
                    if (chg) dwell_d = cnt_q;
                    if (code_new != 3'd0) begin
                        st_d   = FAULT;
                        code_d = code_new;
                        idx_d  = 3'd0;
                    end else if (chg) begin
                        idx_d = s_idx;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q     <= 8'h00;
            prv_q     <= 8'h00;
            sig_vld_q <= 1'b0;
            prv_vld_q <= 1'b0;
            st_q      <= UNSYNC;
            idx_q     <= 3'd0;
            code_q    <= 3'd0;
            cnt_q     <= '0;
            dwell_q   <= '0;
        end else begin
            sig_q     <= sig_d;
            prv_q     <= prv_d;
            sig_vld_q <= sig_vld_d;
            prv_vld_q <= prv_vld_d;
            st_q      <= st_d;
            idx_q     <= idx_d;
            code_q    <= code_d;
            cnt_q     <= cnt_d;
            dwell_q   <= dwell_d;
        end
    end

    assign bus.lane_green = lg;
    assign bus.tracking   = (st_q == TRACK);
    assign bus.phase_idx  = (st_q == TRACK) ? idx_q : 3'd0;
    assign bus.last_dwell = dwell_q;
    assign bus.fault      = (st_q == FAULT);
    assign bus.fault_code = code_q;
endmodule

// File: tb/tb_traffic_signal_monitor.sv
module tb_traffic_signal_monitor;
    localparam int G = 20, Y = 8, T = 2, W = 8;
    localparam logic [7:0] AYW = 8'h55;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    traffic_signal_monitor_if #(.CW(W)) bus ();

    traffic_signal_monitor #(.G_CYC(G), .Y_CYC(Y), .TOL(T), .CW(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] S_W [8] = '{8'h80, 8'h50, 8'h20, 8'h14, 8'h08, 8'h05, 8'h02, 8'h41};

    int n_vec = 0, n_bad = 0;

    // Reference model: the word visible to the monitor, run lengths of the
    // current and previous word, mode 0=unsync 1=track 2=fault.
    logic [7:0] m_vis;
    int  m_nsamp, m_run, m_prev_run, m_mode, m_ph, m_code, m_last;
    bit  m_chg, m_live = 0;

    function automatic int s_index(input logic [7:0] w);
        for (int i = 0; i < 8; i++) if (S_W[i] == w) return i;
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic mdl_edge(input logic [7:0] din, input logic clr, input logic r);
        int c, sidx, greens, lane, exp_d, held;
        bit inv;
        if (r) begin
            m_vis = 8'h00; m_nsamp = 0; m_run = 0; m_prev_run = 0; m_chg = 0;
            m_mode = 0; m_ph = 0; m_code = 0; m_last = 0; m_live = 1;
            return;
        end
        if (!m_live) return;
        c = 0; greens = 0; inv = 0;
        for (int i = 0; i < 4; i++) begin
            lane = (int'(m_vis) >> (6 - 2*i)) & 3;
            if (lane == 2) greens++;
            if (lane == 3) inv = 1;
        end
        sidx  = s_index(m_vis);
        held  = m_chg ? m_prev_run : m_run - 1;
        exp_d = (m_ph % 2 == 0) ? G : Y;
        if (m_mode != 2 && m_nsamp >= 1) begin
            if (greens >= 2)                                         c = 1;
            else if (inv)                                            c = 2;
            else if (sidx < 0 && m_vis != AYW)                       c = 3;
            else if (m_mode == 1 && m_chg && sidx != (m_ph + 1) % 8) c = 4;
            else if (m_mode == 1 && m_chg && m_prev_run < exp_d - T) c = 5;
            else if (m_mode == 1 && held > exp_d + T)                c = 6;
        end
        if (clr) begin
            m_mode = 0; m_code = 0; m_ph = 0;
        end else if (m_mode == 0) begin
            if (c != 0) begin m_mode = 2; m_code = c; end
            else if (m_chg && sidx >= 0) begin m_mode = 1; m_ph = sidx; end
        end else if (m_mode == 1) begin
            if (m_chg) m_last = m_prev_run;
            if (c != 0) begin m_mode = 2; m_code = c; m_ph = 0; end
            else if (m_chg) m_ph = sidx;
        end
        m_chg = (m_nsamp >= 1) && (din != m_vis);
        if (m_chg) begin m_prev_run = m_run; m_run = 1; end
        else m_run = m_run + 1;
        m_vis = din;
        if (m_nsamp < 2) m_nsamp++;
    endtask

    initial forever begin
        @(posedge clk);
        mdl_edge(bus.signal_in, bus.clear_fault, rst);
    end

    // Every-cycle comparison against the model.
    initial forever begin
        logic [3:0] lg;
        @(negedge clk);
        if (m_live) begin
            for (int i = 0; i < 4; i++) lg[i] = (((int'(m_vis) >> (6 - 2*i)) & 3) == 2);
            chk("lane_green", 32'(bus.lane_green), 32'(lg));
            chk("tracking",   32'(bus.tracking),   32'(m_mode == 1));
            chk("phase_idx",  32'(bus.phase_idx),  32'(m_mode == 1 ? m_ph : 0));
            chk("last_dwell", 32'(bus.last_dwell), 32'(m_last));
            chk("fault",      32'(bus.fault),      32'(m_mode == 2));
            chk("fault_code", 32'(bus.fault_code), 32'(m_code));
        end
    end

    task automatic drive(input logic [7:0] w, input int n);
        bus.signal_in = w;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clear();
        bus.clear_fault = 1'b1;
        @(negedge clk);
        bus.clear_fault = 1'b0;
    endtask

    initial begin
        int r, d, ph_b;
        bus.signal_in   = 8'h00;
        bus.clear_fault = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_fault",  32'(bus.fault), 0);
        chk("rst_dwell",  32'(bus.last_dwell), 0);
        chk("rst_track",  32'(bus.tracking), 0);
        rst = 1'b0;

        // Full legal ring, entered from all-yellow.
        drive(AYW, 5);
        for (int p = 0; p < 8; p++) drive(S_W[p], (p % 2) ? Y : G);
        drive(S_W[0], G);
        chk("ring_track", 32'(bus.tracking), 1);
        chk("ring_phase", 32'(bus.phase_idx), 0);
        chk("ring_dwell", 32'(bus.last_dwell), 8);
        chk("ring_green", 32'(bus.lane_green), 32'h1);

        // Two greens while in S2.
        drive(S_W[1], Y); drive(S_W[2], 5);
        drive(8'hA0, 1);
        chk("green2_early", 32'(bus.fault), 0);
        drive(8'hA0, 2);
        chk("green2_fault", 32'(bus.fault), 1);
        chk("green2_code",  32'(bus.fault_code), 1);
        chk("green2_track", 32'(bus.tracking), 0);

        drive(AYW, 2); pulse_clear();
        chk("clr_fault", 32'(bus.fault), 0);
        chk("clr_code",  32'(bus.fault_code), 0);

        // Skipped phase, then AY out of S3.
        drive(S_W[0], G); drive(S_W[1], Y); drive(S_W[4], 3);
        chk("skip_code", 32'(bus.fault_code), 4);
        drive(AYW, 2); pulse_clear();
        drive(S_W[2], G); drive(S_W[3], Y); drive(AYW, 3);
        chk("ay_code", 32'(bus.fault_code), 4);

        // Short green.
        drive(AYW, 2); pulse_clear();
        drive(S_W[4], 15); drive(S_W[5], 3);
        chk("short_code",  32'(bus.fault_code), 5);
        chk("short_dwell", 32'(bus.last_dwell), 15);

        // Long yellow: limit 11, fault on the edge after the counter hits it.
        drive(AYW, 2); pulse_clear();
        drive(S_W[4], G); drive(S_W[5], 12);
        chk("long_early", 32'(bus.fault), 0);
        drive(S_W[5], 1);
        chk("long_code",  32'(bus.fault_code), 6);
        chk("long_dwell", 32'(bus.last_dwell), 20);

        // Invalid lane beats unknown word.
        drive(AYW, 2); pulse_clear();
        drive(8'hC0, 3);
        chk("inv_code", 32'(bus.fault_code), 2);
        drive(AYW, 1); pulse_clear();
        chk("inv_clr", 32'(bus.fault), 0);

        // Reset mid-phase, then a partial first phase.
        drive(S_W[6], G); drive(S_W[7], Y); drive(S_W[0], 10);
        chk("pre_rst_track", 32'(bus.tracking), 1);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        chk("rst2_track", 32'(bus.tracking), 0);
        chk("rst2_green", 32'(bus.lane_green), 0);
        chk("rst2_dwell", 32'(bus.last_dwell), 0);
        drive(S_W[0], 4); drive(S_W[1], Y); drive(S_W[2], 3);
        chk("resync_track", 32'(bus.tracking), 1);
        chk("resync_phase", 32'(bus.phase_idx), 2);
        chk("resync_fault", 32'(bus.fault), 0);
        chk("resync_green", 32'(bus.lane_green), 32'h2);

        // Random walk around the ring with boundary dwells and disturbances.
        ph_b = 3;
        for (int it = 0; it < 250; it++) begin
            r = int'($urandom_range(0, 19));
            if (m_mode == 2 && r < 12) begin
                drive(AYW, int'($urandom_range(1, 3)));
                pulse_clear();
            end else if (r == 0) drive(8'($urandom_range(0, 255)), int'($urandom_range(1, 3)));
            else if (r == 1) pulse_clear();
            else if (r == 2) begin rst = 1'b1; @(negedge clk); rst = 1'b0; end
            else if (r == 3) drive(AYW, int'($urandom_range(1, 4)));
            else if (r == 4) ph_b = (ph_b + 1) % 8;
            else begin
                d = ((ph_b % 2) ? Y : G) + int'($urandom_range(0, 2*T + 2)) - (T + 1);
                drive(S_W[ph_b], d);
                ph_b = (ph_b + 1) % 8;
            end
        end
        drive(AYW, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
